// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID at address 0, timestamp at address 1) and checks both words.
// Optional: define SYSID_CHECK_AUTOSTART_EN to run one check automatically right after reset.
module nios_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5556_C77A,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned RETRY_LIMIT        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    // A zero parameter would give a zero-width counter, so keep at least one bit.
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_GAP,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_to_cnt;
    logic [RW-1:0] r_retry;
    logic          r_gap_ts;
    logic          r_id_ok;
    logic          r_ts_ok;
    logic          r_timeout;
    logic [31:0]   r_cap_id;
    logic [31:0]   r_cap_ts;

    logic          w_start;
    logic          w_in_rd;
    logic          w_accept;
    logic          w_to_hit;
    logic          w_can_retry;
    logic [31:0]   w_to_inc;

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic r_auto;

    always_ff @(posedge clock) begin
        if (reset) r_auto <= 1'b1;
        else       r_auto <= 1'b0;
    end

    assign w_start = start | r_auto;
`else
    assign w_start = start;
`endif

    assign w_in_rd     = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign w_accept    = w_in_rd && !avm_waitrequest;
    assign w_to_inc    = 32'(r_to_cnt) + 32'd1;
    // Fires on the stalled cycle that would bring the count up to TIMEOUT_CYCLES.
    assign w_to_hit    = w_in_rd && avm_waitrequest && (TIMEOUT_CYCLES != 0) &&
                         (w_to_inc >= TIMEOUT_CYCLES);
    assign w_can_retry = (32'(r_retry) < RETRY_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RD_ID;
            S_RD_ID: begin
                if (w_accept)      w_next = S_RD_TS;
                else if (w_to_hit) w_next = w_can_retry ? S_GAP : S_DONE;
            end
            S_RD_TS: begin
                if (w_accept)      w_next = S_DONE;
                else if (w_to_hit) w_next = w_can_retry ? S_GAP : S_DONE;
            end
            S_GAP:   w_next = r_gap_ts ? S_RD_TS : S_RD_ID;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_retry   <= '0;
            r_gap_ts  <= 1'b0;
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
            r_cap_id  <= '0;
            r_cap_ts  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_id_ok   <= 1'b0;
                        r_ts_ok   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_to_cnt  <= '0;
                        r_retry   <= '0;
                    end
                end
                S_RD_ID, S_RD_TS: begin
                    if (w_accept) begin
                        if (r_state == S_RD_ID) begin
                            r_cap_id <= avm_readdata;
                            r_id_ok  <= (avm_readdata == EXPECTED_ID);
                            r_to_cnt <= '0;
                            r_retry  <= '0;
                        end else begin
                            r_cap_ts <= avm_readdata;
                            r_ts_ok  <= (avm_readdata == EXPECTED_TIMESTAMP);
                        end
                    end else begin
                        if (r_to_cnt != '1) r_to_cnt <= r_to_cnt + TW'(1);
                        if (w_to_hit) begin
                            if (w_can_retry) r_gap_ts  <= (r_state == S_RD_TS);
                            else             r_timeout <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    r_to_cnt <= '0;
                    if (r_retry != '1) r_retry <= r_retry + RW'(1);
                end
                default: ;
            endcase
        end
    end

    assign avm_read    = w_in_rd;
    assign avm_address = (r_state == S_RD_TS);
    assign busy        = w_in_rd || (r_state == S_GAP);
    assign done        = (r_state == S_DONE);
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign captured_id = r_cap_id;
    assign captured_ts = r_cap_ts;

endmodule
